// File: rtl/addon_pkg.sv
// Shared types and framing constants for the addon result transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package addon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int   DATA_BITS     = 8;
    localparam int   BYTES_PER_TXN = 2;
    localparam logic START_LVL     = 1'b0;
    localparam logic STOP_LVL      = 1'b1;
    localparam logic IDLE_LVL      = 1'b1;

endpackage

// File: rtl/addon_baud_gen.sv
// Bit-period timer: pulses bit_tick on the last cycle of each CLKS_PER_BIT period.
// Latency: first tick CLKS_PER_BIT cycles after run rises.
// Backpressure: none; counter is held at zero whenever run is low.
module addon_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_tick = run && (cnt == LAST);

endmodule

// File: rtl/addon_uart_tx.sv
// Adds two bytes on start and sends the 9-bit sum as two 8N1 frames (low byte, then carry).
// Latency: tx goes low the cycle after accept; done pulses 20*CLKS_PER_BIT cycles after accept.
// Backpressure: start is ignored while busy; no queuing.
module addon_uart_tx
    import addon_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [8:0] sum_q
);

    state_t     state;
    logic [2:0] bit_cnt;
    logic       byte_idx;
    logic [7:0] shreg;
    logic       bit_tick;
    logic [8:0] sum_nxt;

    assign sum_nxt = {1'b0, op_a} + {1'b0, op_b};

    addon_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .run     (busy),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= IDLE_LVL;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum_q    <= '0;
            bit_cnt  <= '0;
            byte_idx <= 1'b0;
            shreg    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= IDLE_LVL;
                    if (start) begin
                        sum_q    <= sum_nxt;
                        shreg    <= sum_nxt[7:0];
                        busy     <= 1'b1;
                        tx       <= START_LVL;
                        byte_idx <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            tx      <= STOP_LVL;
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (byte_idx == 1'(BYTES_PER_TXN - 1)) begin
                            tx    <= IDLE_LVL;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // Carry byte starts straight after the first stop bit.
                            byte_idx <= 1'b1;
                            shreg    <= {7'b0, sum_q[8]};
                            tx       <= START_LVL;
                            state    <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addon_uart_tx.sv
// Directed bench for addon_uart_tx at CLKS_PER_BIT=4; samples on the falling edge.
module tb_addon_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] op_a = 8'd0;
    logic [7:0] op_b = 8'd0;
    logic       tx;
    logic       busy;
    logic       done;
    logic [8:0] sum_q;

    int errors = 0;
    int checks = 0;

    logic tx_log   [0:199];
    logic busy_log [0:199];
    logic done_log [0:199];

    addon_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op_a (op_a),
        .op_b (op_b),
        .tx   (tx),
        .busy (busy),
        .done (done),
        .sum_q(sum_q)
    );

    always #5 clk = ~clk;

    // Expected line level for frame bit k (0..19) of a transaction carrying sum s.
    function automatic logic exp_bit(input logic [8:0] s, input int k);
        logic [7:0] b;
        int j;
        b = (k < 10) ? s[7:0] : {7'b0, s[8]};
        j = k % 10;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Index i of the logs holds the cycle following the i-th edge after accept.
    task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_log[i]   = tx;
            busy_log[i] = busy;
            done_log[i] = done;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (sum_q !== 9'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", sum_q); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sum_119;
        int ndone;
        pulse_start(8'd20, 8'd99);
        capture(84);
        checks++; if (sum_q !== 9'd119) begin errors++; $display("FAIL s119_sum: got %0d want 119", sum_q); end
        for (int k = 0; k < 20; k++) begin
            logic ok;
            ok = 1'b1;
            for (int c = 0; c < CPB; c++)
                if (tx_log[k*CPB+c] !== exp_bit(9'd119, k)) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL s119_bit%0d: got %b want %b", k, tx_log[k*CPB+1], exp_bit(9'd119, k));
            end
        end
        for (int i = 80; i < 84; i++) begin
            checks++; if (tx_log[i] !== 1'b1) begin errors++; $display("FAIL s119_idle%0d: got %b want 1", i, tx_log[i]); end
        end
        ndone = 0;
        for (int i = 0; i < 84; i++) if (done_log[i] === 1'b1) ndone++;
        checks++; if (done_log[80] !== 1'b1 || ndone != 1) begin errors++; $display("FAIL s119_done: got done80=%b count=%0d want 1/1", done_log[80], ndone); end
        begin
            int nbusy;
            nbusy = 0;
            for (int i = 0; i < 84; i++) if (busy_log[i] === 1'b1) nbusy++;
            checks++; if (nbusy != 80 || busy_log[79] !== 1'b1 || busy_log[80] !== 1'b0) begin
                errors++; $display("FAIL s119_busy: got %0d busy cycles want 80", nbusy);
            end
        end
    endtask

    task automatic test_decode_300;
        int fall;
        logic [7:0] got;
        logic [7:0] want [0:1];
        want[0] = 8'h2C;
        want[1] = 8'h01;
        pulse_start(8'd200, 8'd100);
        capture(84);
        checks++; if (sum_q !== 9'd300) begin errors++; $display("FAIL s300_sum: got %0d want 300", sum_q); end
        fall = -1;
        for (int i = 0; i < 84; i++) if (fall < 0 && tx_log[i] === 1'b0) fall = i;
        checks++; if (fall != 0) begin errors++; $display("FAIL s300_start_pos: got %0d want 0", fall); fall = 0; end
        for (int b = 0; b < 2; b++) begin
            int base;
            base = fall + b*10*CPB;
            for (int j = 0; j < 8; j++) got[j] = tx_log[base + (j+1)*CPB + CPB/2];
            checks++;
            if (tx_log[base + CPB/2] !== 1'b0 || tx_log[base + 9*CPB + CPB/2] !== 1'b1 || got !== want[b]) begin
                errors++; $display("FAIL s300_byte%0d: got %h want %h", b, got, want[b]);
            end
        end
    endtask

    task automatic test_max;
        pulse_start(8'd255, 8'd255);
        capture(84);
        checks++; if (sum_q !== 9'd510) begin errors++; $display("FAIL s510_sum: got %0d want 510", sum_q); end
        for (int b = 0; b < 2; b++) begin
            logic ok;
            ok = 1'b1;
            for (int i = b*40; i < b*40+40; i++)
                if (tx_log[i] !== exp_bit(9'd510, i/CPB)) ok = 1'b0;
            checks++; if (!ok) begin errors++; $display("FAIL s510_frame%0d: got mismatched bits want byte %h", b, (b == 0) ? 8'hFE : 8'h01); end
        end
    endtask

    task automatic test_busy_ignore;
        int ndone;
        logic ok;
        pulse_start(8'd6, 8'd8);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            tx_log[i]   = tx;
            done_log[i] = done;
            if (i == 9) begin op_a = 8'd15; op_b = 8'd112; start = 1'b1; end
            if (i == 10) start = 1'b0;
        end
        checks++; if (sum_q !== 9'd14) begin errors++; $display("FAIL busy_sum: got %0d want 14", sum_q); end
        ok = 1'b1;
        for (int i = 0; i < 80; i++) if (tx_log[i] !== exp_bit(9'd14, i/CPB)) ok = 1'b0;
        for (int i = 80; i < 100; i++) if (tx_log[i] !== 1'b1) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL busy_tx: got line not matching 0E,00 want 0E,00 then idle"); end
        ndone = 0;
        for (int i = 0; i < 100; i++) if (done_log[i] === 1'b1) ndone++;
        checks++; if (ndone != 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_reset_mid;
        logic ok;
        pulse_start(8'd50, 8'd50);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL rmid_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (sum_q !== 9'd0) begin errors++; $display("FAIL rmid_sum: got %0d want 0", sum_q); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rmid_done: got %b want 0", done); end
        pulse_start(8'd1, 8'd2);
        capture(84);
        ok = 1'b1;
        for (int i = 0; i < 80; i++) if (tx_log[i] !== exp_bit(9'd3, i/CPB)) ok = 1'b0;
        checks++; if (!ok || sum_q !== 9'd3 || done_log[80] !== 1'b1) begin
            errors++; $display("FAIL rmid_after: got sum=%0d done80=%b want 3/1 with bytes 03,00", sum_q, done_log[80]);
        end
    endtask

    task automatic test_back_to_back;
        logic ok;
        int ndone;
        @(negedge clk);
        op_a  = 8'd50;
        op_b  = 8'd50;
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            tx_log[i]   = tx;
            busy_log[i] = busy;
            done_log[i] = done;
            if (i == 150) start = 1'b0;
        end
        // Second accept lands on the edge right after the done cycle (index 80).
        checks++; if (done_log[80] !== 1'b1 || busy_log[80] !== 1'b0 || busy_log[81] !== 1'b1) begin
            errors++; $display("FAIL b2b_first_done: got done=%b busy=%b/%b want 1 0/1", done_log[80], busy_log[80], busy_log[81]);
        end
        checks++; if (tx_log[80] !== 1'b1 || tx_log[81] !== 1'b0) begin
            errors++; $display("FAIL b2b_gap: got tx=%b,%b want 1,0", tx_log[80], tx_log[81]);
        end
        ok = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (tx_log[i] !== exp_bit(9'd100, i/CPB)) ok = 1'b0;
            if (tx_log[81+i] !== exp_bit(9'd100, i/CPB)) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL b2b_bytes: got line not matching want 64,00,64,00"); end
        ndone = 0;
        for (int i = 0; i < 170; i++) if (done_log[i] === 1'b1) ndone++;
        checks++; if (done_log[161] !== 1'b1 || ndone != 2) begin
            errors++; $display("FAIL b2b_done: got done161=%b count=%0d want 1/2", done_log[161], ndone);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sum_119();
        test_decode_300();
        test_max();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
